cache_instruction_scheduler: RTL and testbench

// - Issues load/store instructions from NREQ thread requesters into the single two-stage dcache<->regfile load/store pipeline.
// - Round-robin arbitration; at most one issue per cycle.
// - An LAT-deep in-flight tracker blocks RAW hazards through the regfile (store after load, same thread and reg)
//   and through the cache (load after store, same address).
// - Output feeds the pipeline's instruction input; a load means cache->regfile, a store means regfile->cache.

---
 rtl/cache_instruction_scheduler.sv | 133 +++++++++++++
 tb/tb_cache_instruction_scheduler.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/cache_instruction_scheduler.sv
// rtl/cache_instruction_scheduler.sv - round-robin load/store issue into the dcache<->regfile pipeline
// An LAT-deep shift tracker holds in-flight instrs; requesters that would read stale data are held off.
module cache_instruction_scheduler #(
  parameter int NREQ    = 4,
  parameter int LAT     = 3,
  parameter int REG_W   = 2,
  parameter int CADDR_W = 13,
  parameter int CNT_W   = 16,
  localparam int TID_W  = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_is_load,
  input  logic [NREQ*REG_W-1:0]   req_reg,
  input  logic [NREQ*CADDR_W-1:0] req_caddr,
  output logic [NREQ-1:0]         req_ready,
  output logic                    iss_valid,
  output logic                    iss_is_load,
  output logic [TID_W-1:0]        iss_thread,
  output logic [REG_W-1:0]        iss_reg,
  output logic [CADDR_W-1:0]      iss_caddr,
  output logic                    busy,
  output logic [CNT_W-1:0]        stall_cnt
);

  // Index 0 is T[1] (the issue register); index LAT-1 is the oldest tracked instr.
  logic [LAT-1:0]     v_q, ld_q;
  logic [TID_W-1:0]   th_q    [LAT];
  logic [REG_W-1:0]   reg_q   [LAT];
  logic [CADDR_W-1:0] caddr_q [LAT];
  logic [TID_W-1:0]   rr_q;
  logic [CNT_W-1:0]   stall_q;

  logic [NREQ-1:0]    hazard, eligible, grant;
  logic               found;
  logic [TID_W-1:0]   gnt_idx, idx;
  logic [TID_W:0]     sum;
  logic               g_ld;
  logic [REG_W-1:0]   g_reg;
  logic [CADDR_W-1:0] g_caddr;

  always_comb begin
    hazard = '0;
    for (int i = 0; i < NREQ; i++) begin
      for (int k = 0; k < LAT; k++) begin
        if (v_q[k]) begin
          if (req_is_load[i]) begin
            if (!ld_q[k] && caddr_q[k] == req_caddr[i*CADDR_W +: CADDR_W])
              hazard[i] = 1'b1;
          end else if (ld_q[k] && th_q[k] == TID_W'(i) &&
                       reg_q[k] == req_reg[i*REG_W +: REG_W]) begin
            hazard[i] = 1'b1;
          end
        end
      end
    end
  end

  assign eligible = {NREQ{en & rst_n}} & req_valid & ~hazard;

  always_comb begin
    grant   = '0;
    found   = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    sum     = '0;
    for (int j = 0; j < NREQ; j++) begin
      sum = {1'b0, rr_q} + (TID_W+1)'(j);
      if (sum >= (TID_W+1)'(NREQ))
        sum = sum - (TID_W+1)'(NREQ);
      idx = sum[TID_W-1:0];
      if (!found && eligible[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gnt_idx    = idx;
      end
    end
  end

  always_comb begin
    g_ld    = 1'b0;
    g_reg   = '0;
    g_caddr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        g_ld    = req_is_load[i];
        g_reg   = req_reg[i*REG_W +: REG_W];
        g_caddr = req_caddr[i*CADDR_W +: CADDR_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q     <= '0;
      ld_q    <= '0;
      rr_q    <= '0;
      stall_q <= '0;
      for (int k = 0; k < LAT; k++) begin
        th_q[k]    <= '0;
        reg_q[k]   <= '0;
        caddr_q[k] <= '0;
      end
    end else begin
      v_q  <= {v_q[LAT-2:0], found};
      ld_q <= {ld_q[LAT-2:0], g_ld};
      for (int k = 1; k < LAT; k++) begin
        th_q[k]    <= th_q[k-1];
        reg_q[k]   <= reg_q[k-1];
        caddr_q[k] <= caddr_q[k-1];
      end
      th_q[0]    <= gnt_idx;
      reg_q[0]   <= g_reg;
      caddr_q[0] <= g_caddr;
      if (found)
        rr_q <= (gnt_idx == TID_W'(NREQ-1)) ? '0 : gnt_idx + TID_W'(1);
      if (en && (|req_valid) && !found && stall_q != {CNT_W{1'b1}})
        stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign req_ready   = grant;
  assign iss_valid   = v_q[0];
  assign iss_is_load = ld_q[0];
  assign iss_thread  = th_q[0];
  assign iss_reg     = reg_q[0];
  assign iss_caddr   = caddr_q[0];
  assign busy        = |v_q;
  assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_cache_instruction_scheduler.sv
// tb/tb_cache_instruction_scheduler.sv - vector table plus hand sequences with an issue scoreboard
module tb_cache_instruction_scheduler;
  localparam int NREQ = 4, LAT = 3, REG_W = 2, CADDR_W = 13, CNT_W = 10, TID_W = 2;

  logic                    clk = 1'b0;
  logic                    rst_n, en;
  logic [NREQ-1:0]         req_valid, req_is_load, req_ready;
  logic [NREQ*REG_W-1:0]   req_reg;
  logic [NREQ*CADDR_W-1:0] req_caddr;
  logic                    iss_valid, iss_is_load, busy;
  logic [TID_W-1:0]        iss_thread;
  logic [REG_W-1:0]        iss_reg;
  logic [CADDR_W-1:0]      iss_caddr;
  logic [CNT_W-1:0]        stall_cnt;

  cache_instruction_scheduler #(.NREQ(NREQ), .LAT(LAT), .REG_W(REG_W), .CADDR_W(CADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_is_load(req_is_load),
    .req_reg(req_reg), .req_caddr(req_caddr), .req_ready(req_ready), .iss_valid(iss_valid),
    .iss_is_load(iss_is_load), .iss_thread(iss_thread), .iss_reg(iss_reg), .iss_caddr(iss_caddr),
    .busy(busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        e;
    logic [3:0]  v;
    logic [3:0]  ld;
    logic [7:0]  regs;
    logic [51:0] ca;
    logic [3:0]  rdy;
  } vec_t;

  typedef struct {
    logic        ld;
    logic [1:0]  th;
    logic [1:0]  rg;
    logic [12:0] ca;
  } iss_t;

  vec_t             tbl [12];
  iss_t             sbq [$];
  int               total = 0;
  int               bad = 0;
  logic [CNT_W-1:0] exp_stall;
  logic [LAT-1:0]   hist;

  function automatic logic [51:0] pk(input logic [12:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, check outputs of the previous edge and this cycle's grant, advance the model.
  task automatic cyc(input logic r, input logic e, input logic [3:0] v, input logic [3:0] ld,
                     input logic [7:0] regs, input logic [51:0] ca, input logic [3:0] rdy);
    iss_t it;
    rst_n = r; en = e; req_valid = v; req_is_load = ld; req_reg = regs; req_caddr = ca;
    @(negedge clk);
    if (sbq.size() > 0) begin
      it = sbq.pop_front();
      check("iss_valid", iss_valid, 1);
      check("iss_is_load", iss_is_load, it.ld);
      check("iss_thread", iss_thread, it.th);
      check("iss_reg", iss_reg, it.rg);
      check("iss_caddr", iss_caddr, it.ca);
    end else begin
      check("iss_valid_idle", iss_valid, 0);
    end
    check("busy", busy, |hist);
    check("stall_cnt", stall_cnt, exp_stall);
    check("req_ready", req_ready, rdy);
    if (!r) begin
      exp_stall = '0;
      hist = '0;
      sbq.delete();
    end else begin
      hist = {hist[LAT-2:0], |rdy};
      if (e && (|v) && rdy == 4'b0 && exp_stall != {CNT_W{1'b1}})
        exp_stall = exp_stall + CNT_W'(1);
      for (int i = 0; i < NREQ; i++) begin
        if (rdy[i]) begin
          it.ld = ld[i];
          it.th = 2'(i);
          it.rg = regs[i*2 +: 2];
          it.ca = ca[i*13 +: 13];
          sbq.push_back(it);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 1, 4'h0, 4'h0, 8'h00, 52'h0, 4'h0);
  endtask

  initial begin
    logic [51:0] rrca;
    rrca = pk(13'h100, 13'h101, 13'h102, 13'h103);
    tbl[0]  = '{1'b1, 4'hF, 4'h0, 8'hE4, rrca, 4'h1};
    tbl[1]  = '{1'b1, 4'hF, 4'h0, 8'hE4, rrca, 4'h2};
    tbl[2]  = '{1'b1, 4'hF, 4'h0, 8'hE4, rrca, 4'h4};
    tbl[3]  = '{1'b1, 4'hF, 4'h0, 8'hE4, rrca, 4'h8};
    tbl[4]  = '{1'b1, 4'hF, 4'h0, 8'hE4, rrca, 4'h1};
    tbl[5]  = '{1'b1, 4'hF, 4'h0, 8'hE4, rrca, 4'h2};
    tbl[6]  = '{1'b1, 4'h1, 4'h1, 8'h01, pk(13'h010, 13'h0, 13'h0, 13'h0), 4'h1};
    tbl[7]  = '{1'b1, 4'h1, 4'h1, 8'h01, pk(13'h010, 13'h0, 13'h0, 13'h0), 4'h1};
    tbl[8]  = '{1'b1, 4'h4, 4'h0, 8'h10, pk(13'h0, 13'h0, 13'h011, 13'h0), 4'h4};
    tbl[9]  = '{1'b1, 4'h0, 4'h0, 8'h00, 52'h0, 4'h0};
    tbl[10] = '{1'b1, 4'h0, 4'h0, 8'h00, 52'h0, 4'h0};
    tbl[11] = '{1'b1, 4'h0, 4'h0, 8'h00, 52'h0, 4'h0};

    exp_stall = '0;
    hist = '0;
    rst_n = 1'b0; en = 1'b0; req_valid = '0; req_is_load = '0; req_reg = '0; req_caddr = '0;
    @(posedge clk);
    #1;
    cyc(0, 1, 4'hF, 4'h0, 8'hE4, rrca, 4'h0);

    for (int n = 0; n < 12; n++)
      cyc(1, tbl[n].e, tbl[n].v, tbl[n].ld, tbl[n].regs, tbl[n].ca, tbl[n].rdy);

    // Regfile RAW: thread 1 load r2, then store r2 is held while the load is tracked.
    cyc(1, 1, 4'h2, 4'h2, 8'h08, pk(13'h0, 13'h020, 13'h0, 13'h0), 4'h2);
    for (int n = 0; n < LAT; n++)
      cyc(1, 1, 4'h2, 4'h0, 8'h08, pk(13'h0, 13'h021, 13'h0, 13'h0), 4'h0);
    cyc(1, 1, 4'h2, 4'h0, 8'h08, pk(13'h0, 13'h021, 13'h0, 13'h0), 4'h2);
    idle(LAT);

    // Cache RAW: thread 3 load of 0x0A5 waits on thread 0's store; thread 2's 0x0A6 load passes.
    cyc(1, 1, 4'h1, 4'h0, 8'h00, pk(13'h0A5, 13'h0, 13'h0, 13'h0), 4'h1);
    cyc(1, 1, 4'hC, 4'hC, 8'h00, pk(13'h0, 13'h0, 13'h0A6, 13'h0A5), 4'h4);
    cyc(1, 1, 4'h8, 4'h8, 8'h00, pk(13'h0, 13'h0, 13'h0, 13'h0A5), 4'h0);
    cyc(1, 1, 4'h8, 4'h8, 8'h00, pk(13'h0, 13'h0, 13'h0, 13'h0A5), 4'h0);
    cyc(1, 1, 4'h8, 4'h8, 8'h00, pk(13'h0, 13'h0, 13'h0, 13'h0A5), 4'h8);
    idle(LAT);

    // Enable low: no grants, no stall counting, tracker drains, rr pointer holds.
    cyc(1, 1, 4'hF, 4'h0, 8'hE4, rrca, 4'h1);
    for (int n = 0; n < 5; n++) cyc(1, 0, 4'hF, 4'h0, 8'hE4, rrca, 4'h0);
    cyc(1, 1, 4'hF, 4'h0, 8'hE4, rrca, 4'h2);
    idle(LAT);

    // Reset mid-flight clears the tracker, so the dependent store issues immediately after.
    cyc(1, 1, 4'h4, 4'h4, 8'h00, pk(13'h0, 13'h0, 13'h030, 13'h0), 4'h4);
    cyc(0, 1, 4'h4, 4'h0, 8'h00, pk(13'h0, 13'h0, 13'h031, 13'h0), 4'h0);
    check("iss_payload_after_reset", {iss_is_load, iss_thread, iss_reg, iss_caddr}, 0);
    cyc(1, 1, 4'h4, 4'h0, 8'h00, pk(13'h0, 13'h0, 13'h031, 13'h0), 4'h4);
    idle(LAT);

    // Saturation: alternate dependent load/store on thread 0, three stall cycles per issue.
    cyc(1, 1, 4'h1, 4'h1, 8'h00, pk(13'h005, 13'h0, 13'h0, 13'h0), 4'h1);
    for (int n = 0; n < 350; n++) begin
      logic [3:0] kind;
      kind = (n % 2 == 0) ? 4'h0 : 4'h1;
      for (int s = 0; s < LAT; s++)
        cyc(1, 1, 4'h1, kind, 8'h00, pk(13'h005, 13'h0, 13'h0, 13'h0), 4'h0);
      cyc(1, 1, 4'h1, kind, 8'h00, pk(13'h005, 13'h0, 13'h0, 13'h0), 4'h1);
    end
    idle(2);
    check("stall_saturated", stall_cnt, {CNT_W{1'b1}});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end
endmodule
